// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory port, pipeline controls and IF/ID outputs of the fetch stage.
interface fetch_stage_if #(
    parameter int XLEN = 32,
    parameter int AW   = 8
);
    logic [AW-1:0]   imem_read_address;
    logic [XLEN-1:0] imem_data;
    logic            stall;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halt_req;
    logic [XLEN-1:0] pc;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_pc_plus4;
    logic [XLEN-1:0] if_id_instr;
    logic            halted;
    modport master (
        output imem_read_address, pc, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, halted,
        input  imem_data, stall, flush, redirect_valid, redirect_pc, halt_req
    );
    modport slave (
        input  imem_read_address, pc, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, halted,
        output imem_data, stall, flush, redirect_valid, redirect_pc, halt_req
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing with BOOT/RUN/HALTED control and the IF/ID pipeline register.
module fetch_stage #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 256,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input logic           clk,
    input logic           rstn,
    fetch_stage_if.master bus
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d, if_pc4_q, if_pc4_d, if_instr_q, if_instr_d;
    logic            if_valid_q, if_valid_d, halted_q, halted_d;
    logic            run, bubble, capture;
    always_comb begin
        run        = state_q == RUN;
        state_d    = state_q == BOOT ? RUN
                   : (run && bus.halt_req && !bus.redirect_valid) ? HALTED
                   : (state_q == HALTED && bus.redirect_valid) ? RUN
                   : state_q;
        halted_d   = state_d == HALTED;
        pc_d       = bus.redirect_valid ? (bus.redirect_pc & ~XLEN'(3))
                   : (bus.stall || !run) ? pc_q
                   : pc_q + XLEN'(4);
        // a redirect squashes the wrong-path word fetched this cycle
        bubble     = bus.flush || bus.redirect_valid || (!bus.stall && !run);
        capture    = !bubble && !bus.stall;
        if_valid_d = bubble ? 1'b0 : capture ? 1'b1 : if_valid_q;
        if_instr_d = bubble ? NOP : capture ? bus.imem_data : if_instr_q;
        if_pc_d    = capture ? pc_q : if_pc_q;
        if_pc4_d   = capture ? pc_q + XLEN'(4) : if_pc4_q;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
            halted_q   <= halted_d;
        end
    end
    assign bus.imem_read_address = pc_q[AW+1:2];
    assign bus.pc                = pc_q;
    assign bus.if_id_valid       = if_valid_q;
    assign bus.if_id_pc          = if_pc_q;
    assign bus.if_id_pc_plus4    = if_pc4_q;
    assign bus.if_id_instr       = if_instr_q;
    assign bus.halted            = halted_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors, a cycle model checked every falling edge, and literal pins.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    fetch_stage_if #(.XLEN(32), .AW(8)) bus();
    fetch_stage #(.XLEN(32), .IMEM_DEPTH(256), .RESET_PC(32'h0)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    logic [31:0] mem [256];
    assign bus.imem_data = mem[bus.imem_read_address];
    int errors = 0;
    int checks = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // model: mode 0=boot, 1=run, 2=halted
    int          m_mode;
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_v;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_mode <= 0; m_pc <= 0; m_v <= 0; m_instr <= 32'h13; m_ipc <= 0; m_ipc4 <= 0;
        end else begin
            if (bus.redirect_valid) m_pc <= bus.redirect_pc - (bus.redirect_pc % 4);
            else if (!bus.stall && m_mode == 1) m_pc <= m_pc + 4;
            if (bus.flush || bus.redirect_valid || (!bus.stall && m_mode != 1)) begin
                m_v <= 0; m_instr <= 32'h13;
            end else if (!bus.stall) begin
                m_v <= 1; m_ipc <= m_pc; m_ipc4 <= m_pc + 4; m_instr <= mem[(m_pc / 4) % 256];
            end
            if (m_mode == 0) m_mode <= 1;
            else if (m_mode == 1 && bus.halt_req && !bus.redirect_valid) m_mode <= 2;
            else if (m_mode == 2 && bus.redirect_valid) m_mode <= 1;
        end
    end
    always @(negedge clk) begin
        if (rstn) begin
            chk("m_pc", bus.pc, m_pc);
            chk("m_addr", 32'(bus.imem_read_address), (m_pc / 4) % 256);
            chk("m_valid", 32'(bus.if_id_valid), 32'(m_v));
            chk("m_ifpc", bus.if_id_pc, m_ipc);
            chk("m_ifpc4", bus.if_id_pc_plus4, m_ipc4);
            chk("m_instr", bus.if_id_instr, m_instr);
            chk("m_halted", 32'(bus.halted), 32'(m_mode == 2));
        end
    end
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask
    task automatic ifid(input string name, input logic v, input logic [31:0] p, input logic [31:0] ins);
        chk({name, "_valid"}, 32'(bus.if_id_valid), 32'(v));
        chk({name, "_ifpc"}, bus.if_id_pc, p);
        chk({name, "_instr"}, bus.if_id_instr, ins);
    endtask
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        bus.stall = 0; bus.flush = 0; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.halt_req = 0;
        #12;
        chk("rst_pc", bus.pc, 32'h0);
        ifid("rst", 0, 32'h0, 32'h13);
        chk("rst_pc4", bus.if_id_pc_plus4, 32'h0);
        chk("rst_halted", 32'(bus.halted), 0);
        @(negedge clk); #1 rstn = 1;
        cyc(); chk("boot_pc", bus.pc, 32'h0); ifid("boot", 0, 32'h0, 32'h13);
        cyc(); ifid("e2", 1, 32'h0, 32'hA000_0000); chk("e2_pc4", bus.if_id_pc_plus4, 32'h4);
        cyc(); ifid("e3", 1, 32'h4, 32'hA000_0001); chk("e3_pc", bus.pc, 32'h8);
        bus.stall = 1;
        cyc(2); chk("stall_pc", bus.pc, 32'h8); ifid("stall", 1, 32'h4, 32'hA000_0001);
        bus.stall = 0;
        cyc(); ifid("unstall", 1, 32'h8, 32'hA000_0002); chk("unstall_pc", bus.pc, 32'hC);
        cyc(); chk("pc10", bus.pc, 32'h10);
        bus.redirect_valid = 1; bus.redirect_pc = 32'h43; bus.stall = 1;
        cyc(); chk("redir_pc", bus.pc, 32'h40); ifid("redir", 0, 32'hC, 32'h13);
        bus.redirect_valid = 0; bus.stall = 0;
        cyc(); ifid("redir_tgt", 1, 32'h40, 32'hA000_0010); chk("redir_tgt_pc", bus.pc, 32'h44);
        bus.redirect_valid = 1; bus.redirect_pc = 32'h20;
        cyc(); chk("pc20", bus.pc, 32'h20);
        bus.redirect_valid = 0; bus.halt_req = 1;
        cyc(); ifid("halt", 1, 32'h20, 32'hA000_0008); chk("halt_pc", bus.pc, 32'h24);
        chk("halt_flag", 32'(bus.halted), 1);
        cyc(2); chk("halted_pc", bus.pc, 32'h24); ifid("halted", 0, 32'h20, 32'h13);
        chk("halted_flag", 32'(bus.halted), 1);
        bus.halt_req = 0; bus.redirect_valid = 1; bus.redirect_pc = 32'h100;
        cyc(); chk("resume_pc", bus.pc, 32'h100); chk("resume_flag", 32'(bus.halted), 0);
        bus.redirect_valid = 0;
        cyc(); ifid("resume", 1, 32'h100, 32'hA000_0040);
        bus.halt_req = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h200;
        cyc(); chk("halt_redir_flag", 32'(bus.halted), 0); chk("halt_redir_pc", bus.pc, 32'h200);
        bus.halt_req = 0; bus.redirect_valid = 0;
        cyc(); ifid("run200", 1, 32'h200, 32'hA000_0080);
        bus.flush = 1; bus.stall = 1;
        cyc(); chk("fs_pc", bus.pc, 32'h204); ifid("fs", 0, 32'h200, 32'h13);
        bus.stall = 0;
        cyc(); chk("flush_pc", bus.pc, 32'h208); ifid("flush", 0, 32'h200, 32'h13);
        bus.flush = 0; bus.redirect_valid = 1; bus.redirect_pc = 32'hFFFF_FFFC;
        cyc(); chk("top_addr", 32'(bus.imem_read_address), 32'hFF);
        bus.redirect_valid = 0;
        cyc(); chk("wrap_pc", bus.pc, 32'h0); chk("wrap_pc4", bus.if_id_pc_plus4, 32'h0);
        ifid("wrap", 1, 32'hFFFF_FFFC, 32'hA000_00FF);
        bus.redirect_valid = 1; bus.redirect_pc = 32'h400;
        cyc(); chk("a400_addr", 32'(bus.imem_read_address), 32'h0);
        bus.redirect_valid = 1; bus.redirect_pc = 32'h80; bus.halt_req = 1;
        @(posedge clk); #2 rstn = 0;
        #1;
        chk("arst_pc", bus.pc, 32'h0); ifid("arst", 0, 32'h0, 32'h13);
        chk("arst_pc4", bus.if_id_pc_plus4, 32'h0); chk("arst_halted", 32'(bus.halted), 0);
        bus.redirect_valid = 0; bus.halt_req = 0;
        @(negedge clk); #1 rstn = 1;
        cyc(); chk("reboot_pc", bus.pc, 32'h0); ifid("reboot", 0, 32'h0, 32'h13);
        cyc(); ifid("refetch", 1, 32'h0, 32'hA000_0000);
        cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter XLEN, default 32, instruction/PC width in bits.
REQ-002 Parameter IMEM_DEPTH, default 256, instruction memory depth in words; AW = $clog2(IMEM_DEPTH).
REQ-003 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 imem_read_address  output  AW  word address to the combinational-read instruction memory.
REQ-007 imem_data  input  XLEN  instruction returned by memory in the same cycle as imem_read_address.
REQ-008 stall  input  1  hold PC and IF/ID register (downstream hazard).
REQ-009 flush  input  1  replace IF/ID contents with a bubble.
REQ-010 redirect_valid  input  1  taken branch/jump resolved downstream.
REQ-011 redirect_pc  input  XLEN  target PC for redirect.
REQ-012 halt_req  input  1  stop fetching after the current cycle.
REQ-013 pc  output  XLEN  current fetch PC.
REQ-014 if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-015 if_id_pc  output  XLEN  PC of the instruction in IF/ID.
REQ-016 if_id_pc_plus4  output  XLEN  if_id_pc + 4.
REQ-017 if_id_instr  output  XLEN  instruction in IF/ID.
REQ-018 halted  output  1  high while in HALTED state.

Function
REQ-019 imem_read_address SHALL equal pc[AW+1:2], combinationally; pc bits above AW+1 are ignored (address wraps modulo IMEM_DEPTH).
REQ-020 The state machine SHALL have states BOOT, RUN, HALTED; reset enters BOOT.
REQ-021 BOOT SHALL go to RUN after exactly one clock, unconditionally; pc holds and IF/ID stays a bubble during BOOT.
REQ-022 RUN SHALL go to HALTED when halt_req=1 and redirect_valid=0; the instruction fetched in that cycle is still captured (unless stall/flush).
REQ-023 HALTED SHALL go to RUN only on redirect_valid=1; halt_req is ignored outside RUN.
REQ-024 Next pc priority: redirect_valid -> {redirect_pc[XLEN-1:2],2'b00}; else stall or state!=RUN -> hold; else pc+4, wrapping modulo 2^XLEN.
REQ-025 redirect_valid SHALL override stall for the pc update in every state.
REQ-026 IF/ID priority: flush or redirect_valid -> bubble; else stall -> hold all IF/ID fields; else state==RUN -> capture {valid=1, pc, pc+4, imem_data}; else bubble.
REQ-027 Bubble SHALL be if_id_valid=0, if_id_instr=32'h0000_0013 (NOP), if_id_pc and if_id_pc_plus4 unchanged.
REQ-028 Fetch-to-IF/ID latency SHALL be one clock; redirect penalty SHALL be one bubble (first target instruction valid in IF/ID two edges after redirect_valid is sampled).
REQ-029 flush and stall together SHALL produce a bubble in IF/ID while pc holds.
REQ-030 halted SHALL be a registered decode of state==HALTED, no combinational input paths.

Reset
REQ-031 rstn low SHALL asynchronously set pc=RESET_PC, state=BOOT, if_id_valid=0, if_id_instr=32'h0000_0013, if_id_pc=0, if_id_pc_plus4=0, halted=0.
REQ-032 Reset asserted mid-operation SHALL discard any pending redirect or halt; first fetch after release is at RESET_PC following the BOOT cycle.

Verification
REQ-033 Reset release, memory word0=A, word1=B, word2=C -> edge1 BOOT bubble; edge2 IF/ID={1,0x0,A}; edge3 {1,0x4,B}; edge4 {1,0x8,C}.
REQ-034 stall=1 for 2 cycles at pc=0x8 -> pc stays 0x8, IF/ID holds {0x4,B}; after release next capture {0x8,C}.
REQ-035 redirect_valid=1, redirect_pc=0x43 at pc=0x10 with stall=1 -> next pc=0x40, IF/ID bubble (instr 0x13), next edge captures pc 0x40.
REQ-036 halt_req=1 at pc=0x20 -> instr at 0x20 captured, halted=1, pc frozen at 0x24, bubbles thereafter; redirect to 0x100 -> RUN, halted=0, fetch resumes at 0x100.
REQ-037 pc=0xFFFF_FFFC free-running -> next pc=0x0, imem_read_address wraps; pc=0x400 with IMEM_DEPTH=256 -> imem_read_address=0.
REQ-038 rstn asserted while redirect_valid=1 -> outputs reset immediately (asynchronous), redirect discarded, fetch restarts at RESET_PC after BOOT.
